// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the shift-add sequential multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MULT_WIDTH   = 24;
    localparam int MULT_LATENCY = MULT_WIDTH + 2;

endpackage

// File: rtl/iter_counter.sv
// Iteration counter: clears on request, counts while enabled, flags the last iteration.
module iter_counter #(
    parameter int WIDTH = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] cnt;

    assign terminal = (cnt == CNT_W'(WIDTH - 1));

    // Holding at the terminal value keeps the count from wrapping when WIDTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !terminal) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_multiplier_controller.sv
// Controller for the shift-add multiplier: LOAD once, ITER for WIDTH cycles, then a one-cycle DONE.
module seq_multiplier_controller
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic A0,
    output logic loadA,
    output logic loadB,
    output logic initP,
    output logic loadP,
    output logic shiftA,
    output logic Bsel,
    output logic busy,
    output logic done
);

    state_t state;
    state_t state_next;
    logic   cnt_clear;
    logic   cnt_en;
    logic   last_iter;

    iter_counter #(.WIDTH(WIDTH)) u_iter_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .terminal (last_iter)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        loadA      = 1'b0;
        loadB      = 1'b0;
        initP      = 1'b0;
        loadP      = 1'b0;
        shiftA     = 1'b0;
        Bsel       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;

        case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                loadA      = 1'b1;
                loadB      = 1'b1;
                initP      = 1'b1;
                busy       = 1'b1;
                cnt_clear  = 1'b1;
                state_next = ITER;
            end
            ITER: begin
                loadP  = 1'b1;
                shiftA = 1'b1;
                busy   = 1'b1;
                // Mealy steer: the add uses the multiplier bit presented this cycle.
                Bsel   = A0;
                cnt_en = 1'b1;
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Abort only cancels work in flight; DONE always completes its pulse.
        if (abort && (state == LOAD || state == ITER)) begin
            state_next = IDLE;
            cnt_clear  = 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_multiplier_controller.sv
// Bench for seq_multiplier_controller driving a behavioural 24-bit shift-add datapath.
module tb_seq_multiplier_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic a0;
    logic load_a, load_b, init_p, load_p, shift_a, b_sel, busy, done;

    logic [23:0] a_in = '0;
    logic [23:0] b_in = '0;
    logic [23:0] areg = '0;
    logic [23:0] breg = '0;
    logic [23:0] preg = '0;
    logic [24:0] add_bus;

    logic [47:0] exp_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int load_cnt = 0;
    int iter_cnt = 0;
    int done_cnt = 0;
    int last_done = 0;
    int prev_done = 0;
    int start_cyc = 0;

    seq_multiplier_controller dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .A0     (a0),
        .loadA  (load_a),
        .loadB  (load_b),
        .initP  (init_p),
        .loadP  (load_p),
        .shiftA (shift_a),
        .Bsel   (b_sel),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Datapath: {Preg,Areg} shifts right one place per iteration with the conditional add into Preg.
    assign add_bus = {1'b0, preg} + (b_sel ? {1'b0, breg} : 25'd0);
    assign a0      = areg[0];

    always @(posedge clk) begin
        if (load_a) areg <= a_in;
        if (load_b) breg <= b_in;
        if (init_p) preg <= '0;
        if (load_p) preg <= add_bus[24:1];
        if (shift_a) areg <= {add_bus[0], areg[23:1]};
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor and scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (load_a) begin
            load_cnt++;
            exp_q.push_back(48'(a_in) * 48'(b_in));
        end
        if (load_p) iter_cnt++;
        check_eq("bsel", 64'(b_sel), 64'(load_p ? a0 : 1'b0));
        check_eq("excl", 64'({load_a & load_p, init_p & shift_a}), 64'(0));
        check_eq("busy", 64'(busy), 64'(load_a | load_p));
        if (done) begin
            done_cnt++;
            prev_done = last_done;
            last_done = cyc;
            check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) check_eq("product", 64'({preg, areg}), 64'(exp_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [23:0] a, input logic [23:0] b);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        start_cyc = cyc;
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
        end
        check_eq(tag, 64'(seen), 64'(1));
    endtask

    task automatic wait_iters(input int base, input int n);
        int k = 0;
        while ((iter_cnt - base) < n && k < 60) begin
            tick(1);
            k++;
        end
        check_eq("iter_reach", 64'(iter_cnt - base >= n), 64'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_load, base_iter, base_done;

        #1;
        check_eq("reset_outs", 64'({load_a, load_b, init_p, load_p, shift_a, b_sel, busy, done}), 64'(0));
        tick(2);
        rst = 1'b0;
        tick(1);

        // Control pulse counts and latency.
        base_load = load_cnt;
        base_iter = iter_cnt;
        pulse_start(24'h000005, 24'h000003);
        wait_done(40, "t1_done");
        tick(1);
        check_eq("t1_load_cnt", 64'(load_cnt - base_load), 64'(1));
        check_eq("t1_iter_cnt", 64'(iter_cnt - base_iter), 64'(24));
        check_eq("t1_latency", 64'(last_done - start_cyc), 64'(26));

        pulse_start(24'h800000, 24'h000002);
        wait_done(40, "pow2_done");
        tick(1);
        check_eq("pow2_preg", 64'(preg), 64'(24'h000001));
        check_eq("pow2_areg", 64'(areg), 64'(24'h000000));

        pulse_start(24'hFFFFFF, 24'hFFFFFF);
        wait_done(40, "ones_done");
        tick(3);
        check_eq("ones_preg_hold", 64'(preg), 64'(24'hFFFFFE));
        check_eq("ones_areg_hold", 64'(areg), 64'(24'h000001));

        // Random operands.
        for (int i = 0; i < 4; i++) begin
            pulse_start(24'($urandom_range(0, 24'hFFFFFF)), 24'($urandom_range(0, 24'hFFFFFF)));
            wait_done(40, "rand_done");
            tick($urandom_range(1, 3));
        end

        // Asynchronous reset mid-ITER.
        base_iter = iter_cnt;
        base_done = done_cnt;
        pulse_start(24'h000005, 24'h000003);
        wait_iters(base_iter, 10);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_async_outs", 64'({load_a, load_b, init_p, load_p, shift_a, b_sel, busy, done}), 64'(0));
        tick(2);
        rst = 1'b0;
        exp_q.delete();
        tick(30);
        check_eq("rst_no_done", 64'(done_cnt - base_done), 64'(0));
        pulse_start(24'h000007, 24'h000009);
        wait_done(40, "rst_fresh_done");
        tick(1);
        check_eq("rst_fresh_cnt", 64'(done_cnt - base_done), 64'(1));

        // Abort in ITER.
        base_iter = iter_cnt;
        base_done = done_cnt;
        pulse_start(24'h000005, 24'h000003);
        wait_iters(base_iter, 5);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check_eq("abort_idle", 64'({busy, load_p, shift_a}), 64'(0));
        exp_q.delete();
        tick(30);
        check_eq("abort_no_done", 64'(done_cnt - base_done), 64'(0));

        // Stray start while busy and in DONE (with abort in DONE too).
        base_load = load_cnt;
        base_done = done_cnt;
        pulse_start(24'h000006, 24'h000006);
        tick(8);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(40, "stray_done");
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        tick(30);
        check_eq("stray_load_cnt", 64'(load_cnt - base_load), 64'(1));
        check_eq("stray_done_cnt", 64'(done_cnt - base_done), 64'(1));

        // Back-to-back with start held high.
        base_done = done_cnt;
        a_in  = 24'h000003;
        b_in  = 24'h000004;
        start = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("b2b_done_cnt", 64'(done_cnt - base_done), 64'(2));
        check_eq("b2b_spacing", 64'(last_done - prev_done), 64'(27));
        wait_done(40, "b2b_third");
        tick(2);
        check_eq("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_multiplier_controller.md
Name: seq_multiplier_controller

Overview:
- FSM controller that sequences the 24-bit shift-add sequential multiplier datapath.
- Accepts a start pulse and loads the A/B operands while clearing the partial product.
- Runs WIDTH add-shift iterations, steering the add on the datapath's A0 bit each cycle.
- Signals completion with a one-cycle done pulse; the top level pairs it 1:1 with the datapath.

Parameters:
- WIDTH, 24, operand width = number of add-shift iterations; legal range 2 to 64.
- CNT_W, $clog2(WIDTH), iteration counter width; derived, not overridden.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request a multiply; sampled only in IDLE.
- abort, input, 1, synchronous cancel of an in-flight operation.
- A0, input, 1, datapath multiplier LSB (Areg[0]).
- loadA, output, 1, datapath: load multiplier operand.
- loadB, output, 1, datapath: load multiplicand operand.
- initP, output, 1, datapath: clear partial product.
- loadP, output, 1, datapath: capture AddBus[24:1] into Preg.
- shiftA, output, 1, datapath: shift Areg right, inserting AddBus[0].
- Bsel, output, 1, datapath: add Breg (1) or zero (0).
- busy, output, 1, operation in progress (LOAD or ITER).
- done, output, 1, one-cycle pulse; datapath result valid.

Behaviour:
- Reset: state=IDLE, cnt=0.
  - Outputs loadA, loadB, initP, loadP, shiftA, Bsel, busy and done are all 0.
  - rst mid-operation returns to IDLE immediately; a partial result is discarded with no done pulse.
- States: IDLE, LOAD, ITER, DONE. State encoding is binary.
- IDLE: all outputs 0. start=1 at an edge moves to LOAD.
- LOAD (1 cycle):
  - Outputs loadA=loadB=initP=1, busy=1.
  - cnt <= 0; next state ITER.
- ITER (exactly WIDTH cycles):
  - Outputs loadP=shiftA=1, busy=1.
  - Bsel = A0, combinational (Mealy) and valid the same cycle.
  - cnt increments each edge; at cnt==WIDTH-1 the next state is DONE.
- DONE (1 cycle):
  - Outputs done=1, busy=0, all datapath controls 0.
  - Next state is IDLE unconditionally.
  - start during DONE is ignored, giving one dead cycle between operations.
- Latency: start sampled at edge k gives LOAD in cycle k+1, ITER in cycles k+2..k+WIDTH+1, and done=1 in cycle k+WIDTH+2 (26 cycles for WIDTH=24).
- Result hold: Preg and Areg hold after done until the next LOAD, because the controller never asserts loadP or shiftA outside ITER.
- Operand sampling: operands A and B are sampled by the datapath at the end of the LOAD cycle only.
  - A and B must be stable in LOAD; changes afterwards have no effect.
- Simultaneous-event priority: rst > abort > normal transition.
  - abort=1 in LOAD or ITER forces IDLE next cycle, cnt <= 0, no done.
  - abort in IDLE or DONE has no effect; DONE still pulses.
- start held high continuously: a new operation begins every WIDTH+3 cycles (IDLE re-samples start).
- Control exclusivity: loadA/initP and loadP/shiftA are never asserted in the same cycle.
- Counter: the counter never wraps; it is reloaded in LOAD and is unused in other states.

Decomposition:
- Package seq_mult_pkg:
  - state enum (IDLE, LOAD, ITER, DONE);
  - localparam MULT_WIDTH=24;
  - localparam MULT_LATENCY=MULT_WIDTH+2.
- Optional sub-module iter_counter: a CNT_W-bit up-counter with clear, enable and a terminal flag (cnt==WIDTH-1).
- The FSM and output decode stay in the controller.

Test Plan:
- Reset mid-ITER: start, then assert rst at ITER cycle 10.
  - Required: all outputs 0 asynchronously, state IDLE, no done.
  - A fresh start afterwards completes normally.
- Control pulse count: start with A=24'h000005, B=24'h000003.
  - Required: LOAD pulses for exactly 1 cycle, loadP/shiftA for exactly 24 cycles.
  - Required: Bsel equals A0 in every ITER cycle, done exactly 26 cycles after start.
- Datapath pair, power-of-two: A=24'h800000, B=24'h000002.
  - Required: at done, Preg=24'h000001 and Areg=24'h000000.
- Datapath pair, all-ones: A=B=24'hFFFFFF.
  - Required: at done, Preg=24'hFFFFFE and Areg=24'h000001.
- Abort and stray start: abort at ITER cycle 5.
  - Required: IDLE next cycle, busy=0, no done.
  - start pulsed during busy and during DONE is ignored; no extra LOAD.
- Back-to-back: start held high for 60 cycles.
  - Required: exactly 2 done pulses, 27 cycles apart.
